mix_sequencer: RTL
==================

# mix_sequencer

Timed valve/pump sequencer for the three-inlet mixing network: soln2 through the serpentine delay chain, soln1 into the first diffusion mixer, soln3 through the serpentine sub-chain, then a second mix and dispense through the output serpentine. One run starts per accepted request. The block walks a fixed phase order, holds each phase for a programmed number of cycles, and drives registered valve/pump enables. It sits between the host command interface and the off-chip valve drivers.

## Interface
- CNT_W, 16, width of the phase duration inputs and the internal timer
- FLUSH_CYC, 8, FLUSH phase length in cycles (used only with flush compiled in)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start_valid  in  1  run request
- start_ready  out  1  high only in IDLE
- t_prime, t_mix0, t_sub, t_dwell, t_dispense  in  CNT_W each  phase durations in cycles, sampled on accept
- abort  in  1  cancel the current run
- valve_soln1, valve_soln2, valve_soln3  out  1 each  inlet valve enables
- valve_out  out  1  outlet valve enable
- pump_en  out  1  pressure pump enable
- phase  out  3  current state encoding
- done  out  1  one-cycle pulse when a run completes
- aborted  out  1  one-cycle pulse when a run is aborted
- run_cnt  out  8  number of completed runs, wraps 255 -> 0

## Operation
- Reset values: all valves 0, pump_en 0, phase 0, done 0, aborted 0, run_cnt 0, start_ready 1.
- Phase encoding: IDLE 0, PRIME 1, MIX0 2, SUB 3, DWELL 4, DISPENSE 5, FLUSH 6.
- Accept: start_valid & start_ready. The five durations are latched on accept. Later changes to them have no effect on the run in progress.
- Transitions: IDLE -> PRIME -> MIX0 -> SUB -> DWELL -> DISPENSE -> IDLE. FLUSH is inserted between DISPENSE and IDLE when compiled in.
- Duration N means the phase lasts N cycles. N=0 is treated as 1.
- Timer behaviour: on phase entry the timer loads max(N,1)-1 and decrements each cycle. The phase advances on the cycle the timer reads 0.
- Valves active per phase:
  - PRIME: soln2, pump.
  - MIX0: soln1, soln2, pump.
  - SUB: soln1, soln2, soln3, pump.
  - DWELL: nothing (all 0).
  - DISPENSE: soln2, out, pump.
  - FLUSH: all four valves, pump.
  - IDLE: all 0.
- done pulses in the first IDLE cycle after the run, and run_cnt increments in that same cycle.
- abort is ignored in IDLE. In any other state it forces IDLE on the next edge with all outputs 0 and pulses aborted. done does not pulse and run_cnt does not increment.
- If abort arrives in the final cycle of the final phase, abort wins.
- start_valid while busy is ignored (start_ready=0). A start may be accepted in the same cycle done is high.

## Timing
- All outputs are registered and change only on clk rising edges, except asynchronous reset, which clears them immediately.
- Accept at cycle T: PRIME outputs are visible at T+1.
- Total run length: sum of max(Ni,1) phase cycles, plus FLUSH_CYC if flush is compiled in. done is asserted at T+1+total.
- phase and the valve outputs always update on the same edge and match each other.
- Reset asserted mid-run: outputs clear immediately and the block returns to IDLE. No done or aborted pulse on reset release.

## Configuration
- MIX_SEQ_FLUSH_EN defined: DISPENSE -> FLUSH(FLUSH_CYC cycles, with FLUSH_CYC=0 treated as 1) -> IDLE, and done pulses after FLUSH.
- MIX_SEQ_FLUSH_EN undefined: DISPENSE -> IDLE. Encoding 6 is never produced and the FLUSH_CYC parameter is unused.

## Structure
- mix_seq_pkg contains:
  - state enum (3-bit) and phase encodings;
  - valve-mask typedef (5-bit: soln1, soln2, soln3, out, pump);
  - constant per-phase valve table.
- phase_timer is the single sub-module: loadable CNT_W down-counter with a load input and a zero flag.
- The top level holds the FSM, the latched durations and run_cnt.

## Test plan
- Reset: rst_n=0 -> all valves/pump 0, phase 0, start_ready 1, run_cnt 0. Same result when reset is pulsed mid-DISPENSE.
- Nominal run, with t_prime=3, t_mix0=2, t_sub=4, t_dwell=1, t_dispense=2 and start accepted at T:
  - PRIME T+1..3, MIX0 T+4..5, SUB T+6..9, DWELL T+10, DISPENSE T+11..12;
  - done at T+13, run_cnt=1.
- All durations 0 -> each phase lasts 1 cycle, done at T+6 (T+10 with flush compiled in and FLUSH_CYC=4).
- abort in the 2nd SUB cycle -> all outputs 0 next cycle, aborted pulse, no done, run_cnt unchanged, start_ready 1.
- Busy behaviour:
  - start_valid held during a run, with t_* changed mid-run -> no second accept and phase timing unchanged;
  - a restart accepted on the done cycle begins PRIME on the next cycle.
- 256 back-to-back minimum runs -> run_cnt wraps to 0; abort coinciding with the final DISPENSE cycle -> aborted pulses, done does not.

Source files
------------

// File: rtl/mix_seq_pkg.sv
// mix_seq_pkg: shared types and constants for the mixing-network sequencer.
//   state_e       3-bit phase/state encoding (also driven on the phase output)
//   valve_mask_t  5-bit valve/pump enable bundle {soln1, soln2, soln3, out, pump}
//   valve_for()   constant per-phase valve table
package mix_seq_pkg;

    localparam int unsigned PHASE_W  = 3;
    localparam int unsigned NUM_DUR  = 5;
    localparam int unsigned RUN_CNT_W = 8;

    // Index of each programmed duration inside the latched duration array
    localparam int unsigned DUR_PRIME    = 0;
    localparam int unsigned DUR_MIX0     = 1;
    localparam int unsigned DUR_SUB      = 2;
    localparam int unsigned DUR_DWELL    = 3;
    localparam int unsigned DUR_DISPENSE = 4;

    typedef enum logic [PHASE_W-1:0] {
        S_IDLE     = 3'd0,
        S_PRIME    = 3'd1,
        S_MIX0     = 3'd2,
        S_SUB      = 3'd3,
        S_DWELL    = 3'd4,
        S_DISPENSE = 3'd5,
        S_FLUSH    = 3'd6
    } state_e;

    typedef struct packed {
        logic soln1;
        logic soln2;
        logic soln3;
        logic out;
        logic pump;
    } valve_mask_t;

    localparam valve_mask_t VALVES_OFF      = '{soln1: 1'b0, soln2: 1'b0, soln3: 1'b0, out: 1'b0, pump: 1'b0};
    localparam valve_mask_t VALVES_PRIME    = '{soln1: 1'b0, soln2: 1'b1, soln3: 1'b0, out: 1'b0, pump: 1'b1};
    localparam valve_mask_t VALVES_MIX0     = '{soln1: 1'b1, soln2: 1'b1, soln3: 1'b0, out: 1'b0, pump: 1'b1};
    localparam valve_mask_t VALVES_SUB      = '{soln1: 1'b1, soln2: 1'b1, soln3: 1'b1, out: 1'b0, pump: 1'b1};
    localparam valve_mask_t VALVES_DISPENSE = '{soln1: 1'b0, soln2: 1'b1, soln3: 1'b0, out: 1'b1, pump: 1'b1};
    localparam valve_mask_t VALVES_FLUSH    = '{soln1: 1'b1, soln2: 1'b1, soln3: 1'b1, out: 1'b1, pump: 1'b1};

    // Valve/pump enables that belong to each phase
    function automatic valve_mask_t valve_for(input state_e s);
        valve_mask_t m;
        m = VALVES_OFF;
        case (s)
            S_PRIME:    m = VALVES_PRIME;
            S_MIX0:     m = VALVES_MIX0;
            S_SUB:      m = VALVES_SUB;
            S_DISPENSE: m = VALVES_DISPENSE;
            S_FLUSH:    m = VALVES_FLUSH;
            default:    m = VALVES_OFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mix_sequencer_timer.sv
// phase_timer: loadable down-counter that times one sequencer phase.
//   clk, rst_n  clock / async active-low reset
//   load        load load_val this cycle (takes priority over decrement)
//   load_val    CNT_W value loaded on load
//   zero_c      combinational flag, counter currently reads 0
// The counter holds at 0 rather than wrapping, so an idle timer stays quiet.
module phase_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; otherwise count down and saturate at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mix_sequencer.sv
// mix_sequencer: timed valve/pump sequencer for the three-inlet mixing network.
// Walks IDLE -> PRIME -> MIX0 -> SUB -> DWELL -> DISPENSE [-> FLUSH] -> IDLE,
// holding each phase for its latched duration (0 treated as 1).
// Optional feature macro: MIX_SEQ_FLUSH_EN inserts FLUSH (FLUSH_CYC cycles)
// between DISPENSE and IDLE.
// Ports:
//   clk, rst_n                    clock / async active-low reset
//   start_valid, start_ready      run request handshake (ready only in IDLE)
//   t_prime..t_dispense           phase durations, latched on accept
//   abort                         cancel the current run (ignored in IDLE)
//   valve_soln1/2/3, valve_out    registered valve enables
//   pump_en                       registered pump enable
//   phase                         current state encoding
//   done, aborted                 one-cycle completion / cancel pulses
//   run_cnt                       completed-run counter, wraps at 256
module mix_sequencer
    import mix_seq_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned FLUSH_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [CNT_W-1:0]     t_prime,
    input  logic [CNT_W-1:0]     t_mix0,
    input  logic [CNT_W-1:0]     t_sub,
    input  logic [CNT_W-1:0]     t_dwell,
    input  logic [CNT_W-1:0]     t_dispense,
    input  logic                 abort,
    output logic                 valve_soln1,
    output logic                 valve_soln2,
    output logic                 valve_soln3,
    output logic                 valve_out,
    output logic                 pump_en,
    output logic [PHASE_W-1:0]   phase,
    output logic                 done,
    output logic                 aborted,
    output logic [RUN_CNT_W-1:0] run_cnt
);

    // Timer load value for FLUSH, with a zero length treated as one cycle
    localparam logic [CNT_W-1:0] FLUSH_LOAD =
        CNT_W'((FLUSH_CYC == 32'd0) ? 32'd0 : (FLUSH_CYC - 32'd1));

    state_e                          state_q, state_d;
    logic [NUM_DUR-1:0][CNT_W-1:0]   dur_q, dur_d;
    valve_mask_t                     valve_q, valve_d;
    logic                            done_q, done_d;
    logic                            aborted_q, aborted_d;
    logic                            start_ready_q, start_ready_d;
    logic [RUN_CNT_W-1:0]            run_cnt_q, run_cnt_d;

    logic                            tmr_load;
    logic [CNT_W-1:0]                tmr_val;
    logic                            tmr_zero_c;

    // Timer reload for a programmed duration: max(n,1)-1
    function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : (n - CNT_W'(1));
    endfunction

    // Fixed phase order; FLUSH is only reachable when compiled in
    function automatic state_e next_phase(input state_e s);
        state_e n;
        n = S_IDLE;
        case (s)
            S_PRIME:    n = S_MIX0;
            S_MIX0:     n = S_SUB;
            S_SUB:      n = S_DWELL;
            S_DWELL:    n = S_DISPENSE;
`ifdef MIX_SEQ_FLUSH_EN
            S_DISPENSE: n = S_FLUSH;
`else
            S_DISPENSE: n = S_IDLE;
`endif
            S_FLUSH:    n = S_IDLE;
            default:    n = S_IDLE;
        endcase
        return n;
    endfunction

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    // Next-state, duration latch, timer reload and registered-output values
    always_comb begin
        state_d       = state_q;
        dur_d         = dur_q;
        done_d        = 1'b0;
        aborted_d     = 1'b0;
        run_cnt_d     = run_cnt_q;
        tmr_load      = 1'b0;
        tmr_val       = '0;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    state_d = S_PRIME;
                    dur_d   = {t_dispense, t_dwell, t_sub, t_mix0, t_prime};
                end
            end
            default: begin
                // abort beats a simultaneous end-of-run
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (tmr_zero_c) begin
                    state_d = next_phase(state_q);
                    if (state_d == S_IDLE) begin
                        done_d    = 1'b1;
                        run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
                    end
                end
            end
        endcase

        // Reload the timer on entry to every timed phase (uses dur_d so the
        // accept cycle sees the freshly sampled durations)
        if (state_d != state_q) begin
            tmr_load = 1'b1;
            case (state_d)
                S_PRIME:    tmr_val = load_of(dur_d[DUR_PRIME]);
                S_MIX0:     tmr_val = load_of(dur_d[DUR_MIX0]);
                S_SUB:      tmr_val = load_of(dur_d[DUR_SUB]);
                S_DWELL:    tmr_val = load_of(dur_d[DUR_DWELL]);
                S_DISPENSE: tmr_val = load_of(dur_d[DUR_DISPENSE]);
                S_FLUSH:    tmr_val = FLUSH_LOAD;
                default:    tmr_load = 1'b0;
            endcase
        end

        valve_d       = valve_for(state_d);
        start_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            dur_q         <= '0;
            valve_q       <= VALVES_OFF;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            start_ready_q <= 1'b1;
            run_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            dur_q         <= dur_d;
            valve_q       <= valve_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            start_ready_q <= start_ready_d;
            run_cnt_q     <= run_cnt_d;
        end
    end

    assign phase       = state_q;
    assign valve_soln1 = valve_q.soln1;
    assign valve_soln2 = valve_q.soln2;
    assign valve_soln3 = valve_q.soln3;
    assign valve_out   = valve_q.out;
    assign pump_en     = valve_q.pump;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign start_ready = start_ready_q;
    assign run_cnt     = run_cnt_q;

endmodule
